// File: rtl/eth_vlg_pkg.sv
// eth_vlg_pkg: shared types for the eth_vlg TX path.
// Latency: n/a (types only).
// Backpressure: n/a.
package eth_vlg_pkg;

  // Arbiter states: wait for a request, one-cycle grant setup, frame
  // pass-through, then the inter-frame gap.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    XFER  = 2'd2,
    GAP   = 2'd3
  } arb_state_t;

endpackage

// File: rtl/eth_vlg_rr_pick.sv
// eth_vlg_rr_pick: rotating-priority encoder; the search starts just above `last`, modulo N.
// Latency: combinational.
// Backpressure: none, pure function of req/last.
// Ports: req  - request vector, one bit per source
//        last - index granted most recently (lowest priority this round)
//        val  - at least one request present
//        idx  - chosen source index (0 when val=0)
module eth_vlg_rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic          val,
  output logic [IW-1:0] idx
);

  int cand;

  always_comb begin
    val  = 1'b0;
    idx  = '0;
    cand = 0;
    // Walk from the farthest candidate to the nearest one so the requester
    // closest after `last` is the final writer. The modulo keeps the
    // rotation exact when N is not a power of two.
    for (int k = N; k >= 1; k--) begin
      cand = (int'(last) + k) % N;
      if (req[IW'(cand)]) begin
        val = 1'b1;
        idx = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/eth_vlg_tx_arb.sv
// eth_vlg_tx_arb: packet-granular round-robin arbiter sharing one MAC TX byte stream.
// Latency: 1 cycle request-to-grant, 1 GRANT cycle, then zero-latency data pass-through.
// Backpressure: out_cts is passed straight to the granted source's req_cts; IFG gap after each frame.
// Ports: clk/rst                    - clock, asynchronous active-low reset
//        req_val/req_dat/req_eof    - per-source byte stream, source i at [i*W +: W]
//        req_cts                    - per-source clear-to-send, one-hot or zero
//        out_val/out_dat/out_eof    - byte stream to the MAC, out_cts is the MAC ready
//        out_abort                  - one-cycle pulse: drop the frame in progress
//        gnt_idx                    - current or most recent grant
//        busy                       - high in GRANT, XFER and GAP
module eth_vlg_tx_arb
  import eth_vlg_pkg::*;
#(
  parameter int N       = 4,
  parameter int W       = 8,
  parameter int IFG     = 12,
  parameter int TIMEOUT = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req_val,
  input  logic [N*W-1:0]       req_dat,
  input  logic [N-1:0]         req_eof,
  output logic [N-1:0]         req_cts,
  output logic                 out_val,
  output logic [W-1:0]         out_dat,
  output logic                 out_eof,
  input  logic                 out_cts,
  output logic                 out_abort,
  output logic [$clog2(N)-1:0] gnt_idx,
  output logic                 busy
);

  localparam int IW  = $clog2(N);
  localparam int WDW = $clog2(TIMEOUT);
  localparam int IFW = (IFG > 0) ? $clog2(IFG + 1) : 1;
  // With IFG=0 a frame end goes straight back to IDLE, which still
  // guarantees one idle cycle between frames.
  localparam arb_state_t END_STATE = (IFG > 0) ? GAP : IDLE;

  arb_state_t     state_q, state_d;
  logic [IW-1:0]  gnt_q, gnt_d;
  logic [IW-1:0]  last_q, last_d;
  logic [WDW-1:0] wd_q, wd_d;
  logic [IFW-1:0] ifg_q, ifg_d;

  logic           pick_val;
  logic [IW-1:0]  pick_idx;
  logic [W-1:0]   dat_arr [N];
  logic           g_val;
  logic           g_eof;
  logic [W-1:0]   g_dat;
  logic           beat;
  logic           stall;

  eth_vlg_rr_pick #(
    .N  (N),
    .IW (IW)
  ) u_pick (
    .req  (req_val),
    .last (last_q),
    .val  (pick_val),
    .idx  (pick_idx)
  );

  always_comb begin
    for (int i = 0; i < N; i++) begin
      dat_arr[i] = req_dat[i*W +: W];
    end
  end

  assign g_val = req_val[gnt_q];
  assign g_eof = req_eof[gnt_q];
  assign g_dat = dat_arr[gnt_q];
  assign beat  = g_val && out_cts;
  // Only a missing byte counts as a stall; MAC backpressure never arms the watchdog.
  assign stall = !g_val && out_cts;

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    last_d    = last_q;
    wd_d      = wd_q;
    ifg_d     = ifg_q;
    req_cts   = '0;
    out_val   = 1'b0;
    out_dat   = '0;
    out_eof   = 1'b0;
    out_abort = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (pick_val) begin
          gnt_d   = pick_idx;
          state_d = GRANT;
        end
      end

      GRANT: begin
        // The grant holds even if the source has since dropped val.
        req_cts[gnt_q] = out_cts;
        wd_d           = '0;
        state_d        = XFER;
      end

      XFER: begin
        out_val        = g_val;
        out_dat        = g_dat;
        out_eof        = g_eof;
        req_cts[gnt_q] = out_cts;
        // beat and stall are exclusive, so an eof beat landing on the
        // expiry count completes the frame instead of aborting it.
        if (beat) begin
          wd_d = '0;
          if (g_eof) begin
            last_d  = gnt_q;
            ifg_d   = '0;
            state_d = END_STATE;
          end
        end else if (stall) begin
          if (wd_q == WDW'(TIMEOUT - 1)) begin
            out_abort = 1'b1;
            req_cts   = '0;
            last_d    = gnt_q;
            wd_d      = '0;
            ifg_d     = '0;
            state_d   = END_STATE;
          end else begin
            wd_d = wd_q + 1'b1;
          end
        end
      end

      GAP: begin
        if (ifg_q == IFW'(IFG - 1)) begin
          ifg_d   = '0;
          state_d = IDLE;
        end else begin
          ifg_d = ifg_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      gnt_q   <= IW'(N - 1);
      last_q  <= IW'(N - 1);
      wd_q    <= '0;
      ifg_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      wd_q    <= wd_d;
      ifg_q   <= ifg_d;
    end
  end

  assign gnt_idx = gnt_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_eth_vlg_tx_arb.sv
// tb_eth_vlg_tx_arb: scoreboard bench for eth_vlg_tx_arb.
// Sources are queue-driven byte streams; a negedge monitor tracks each frame
// against round-robin, gap and watchdog rules computed from plain counters.
module tb_eth_vlg_tx_arb;

  localparam int N       = 4;
  localparam int W       = 8;
  localparam int IFG     = 12;
  localparam int TIMEOUT = 256;

  localparam int P_IDLE = 0;
  localparam int P_XFER = 1;
  localparam int P_GAP  = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req_val = '0;
  logic [N*W-1:0] req_dat = '0;
  logic [N-1:0]   req_eof = '0;
  logic [N-1:0]   req_cts;
  logic           out_val;
  logic [W-1:0]   out_dat;
  logic           out_eof;
  logic           out_cts = 1'b1;
  logic           out_abort;
  logic [1:0]     gnt_idx;
  logic           busy;

  eth_vlg_tx_arb #(
    .N       (N),
    .W       (W),
    .IFG     (IFG),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst       (rst_n),
    .req_val   (req_val),
    .req_dat   (req_dat),
    .req_eof   (req_eof),
    .req_cts   (req_cts),
    .out_val   (out_val),
    .out_dat   (out_dat),
    .out_eof   (out_eof),
    .out_cts   (out_cts),
    .out_abort (out_abort),
    .gnt_idx   (gnt_idx),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Source-side frame storage and scoreboard copy.
  logic [7:0] src_b [N][$];
  int         src_len [N][$];
  logic [7:0] exp_b [N][$];
  int         exp_len [N][$];

  int ptr [N];
  int hold [N];
  int stall_at [N];
  int stall_len [N];
  bit acc [N];
  bit abt [N];
  int cts_mode = 0;

  // Monitor / reference model state.
  int         ph = P_IDLE;
  bit         have_prev = 0;
  logic [N-1:0] prev_req = '0;
  int         m_last = N - 1;
  int         g = 0;
  int         pos = 0;
  int         stall = 0;
  int         gcnt = 0;
  int         x_cyc = 0;
  int         last_xfer_cyc = 0;
  int         abort_cnt = 0;
  int         abort_gi = 0;
  int         grant_log [$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d..%0d t=%0t", nm, act, lo, hi, $time);
    end
  endtask

  // Round-robin rule: first requester after `last`, wrapping modulo N.
  function automatic int winner(input logic [N-1:0] r, input int last);
    for (int k = 1; k <= N; k++) begin
      if (r[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  function automatic bit all_empty();
    for (int i = 0; i < N; i++) begin
      if (src_len[i].size() != 0 || exp_len[i].size() != 0) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic send(input int s, input int len);
    logic [7:0] b;
    for (int k = 0; k < len; k++) begin
      b = 8'($urandom);
      src_b[s].push_back(b);
      exp_b[s].push_back(b);
    end
    src_len[s].push_back(len);
    exp_len[s].push_back(len);
  endtask

  task automatic drain(input string nm, input int budget);
    int c;
    c = 0;
    while (c < budget && !(all_empty() && ph == P_IDLE && have_prev && !busy)) begin
      @(negedge clk);
      c++;
    end
    checks++;
    if (c >= budget) begin
      errors++;
      $display("FAIL %s timeout actual=%0d cycles required=<%0d", nm, c, budget);
    end
  endtask

  task automatic wait_ptr(input string nm, input int s, input int v, input int budget);
    int c;
    c = 0;
    while (c < budget && ptr[s] < v) begin
      @(negedge clk);
      c++;
    end
    checks++;
    if (c >= budget) begin
      errors++;
      $display("FAIL %s timeout actual=%0d required=%0d", nm, ptr[s], v);
    end
  endtask

  // Capture handshakes on the stable half of the cycle.
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      acc[i] = rst_n && out_val && out_cts && (gnt_idx == 2'(i));
      abt[i] = rst_n && out_abort && (gnt_idx == 2'(i));
    end
  end

  // Source drivers and MAC ready, updated just after each rising edge.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < N; i++) begin
      if (!rst_n) begin
        ptr[i]  = 0;
        hold[i] = 0;
      end else begin
        if (acc[i] && src_len[i].size() > 0) begin
          if (ptr[i] == src_len[i][0] - 1) begin
            repeat (src_len[i][0]) void'(src_b[i].pop_front());
            void'(src_len[i].pop_front());
            ptr[i] = 0;
          end else begin
            ptr[i]++;
          end
        end
        if (abt[i]) ptr[i] = 0;
        if (stall_at[i] >= 0 && ptr[i] == stall_at[i] && src_len[i].size() > 0) begin
          hold[i]     = stall_len[i];
          stall_at[i] = -1;
        end
      end
      acc[i] = 1'b0;
      abt[i] = 1'b0;
      if (hold[i] > 0) begin
        req_val[i]         = 1'b0;
        req_eof[i]         = 1'b0;
        req_dat[i*W +: W]  = '0;
        hold[i]--;
      end else if (src_len[i].size() > 0) begin
        req_val[i]         = 1'b1;
        req_dat[i*W +: W]  = src_b[i][ptr[i]];
        req_eof[i]         = (ptr[i] == src_len[i][0] - 1);
      end else begin
        req_val[i]         = 1'b0;
        req_eof[i]         = 1'b0;
        req_dat[i*W +: W]  = '0;
      end
    end
    case (cts_mode)
      0:       out_cts = 1'b1;
      1:       out_cts = !out_cts;
      default: out_cts = ($urandom_range(3) != 0);
    endcase
  end

  // Monitor: frame-level reference model plus scoreboard pops.
  always @(negedge clk) begin
    logic [N-1:0] exp_cts;
    bit           exp_ab;
    bit           beat;
    bit           last_beat;
    if (!rst_n) begin
      ph        = P_IDLE;
      have_prev = 1'b0;
      m_last    = N - 1;
      pos       = 0;
      stall     = 0;
    end else begin
      case (ph)
        P_IDLE: begin
          chk("idle_abort", out_abort, 0);
          if (have_prev && prev_req != '0) begin
            g = winner(prev_req, m_last);
            exp_cts    = '0;
            exp_cts[g] = out_cts;
            chk("arb_busy", busy, 1);
            chk("arb_idx", gnt_idx, g);
            chk("grant_cts", req_cts, exp_cts);
            chk("grant_outval", out_val, 0);
            grant_log.push_back(g);
            pos   = 0;
            stall = 0;
            x_cyc = 0;
            ph    = P_XFER;
          end else begin
            if (have_prev) chk("idle_busy", busy, 0);
            chk("idle_cts", req_cts, 0);
            chk("idle_outval", out_val, 0);
            prev_req  = req_val;
            have_prev = 1'b1;
          end
        end

        P_XFER: begin
          x_cyc++;
          exp_ab    = 1'b0;
          beat      = req_val[g] && out_cts;
          last_beat = 1'b0;
          if (!beat && !req_val[g] && out_cts) begin
            stall++;
            exp_ab = (stall == TIMEOUT);
          end
          chk("xfer_val", out_val, req_val[g]);
          chk("xfer_dat", out_dat, req_dat[g*W +: W]);
          chk("xfer_eof", out_eof, req_eof[g]);
          chk("xfer_abort", out_abort, exp_ab);
          exp_cts = '0;
          if (!exp_ab) exp_cts[g] = out_cts;
          chk("xfer_cts", req_cts, exp_cts);
          if (beat) begin
            stall = 0;
            if (exp_len[g].size() == 0) begin
              checks++;
              errors++;
              $display("FAIL beat_unexpected actual=src%0d required=no beat", g);
            end else begin
              last_beat = (pos == exp_len[g][0] - 1);
              chk("beat_dat", out_dat, exp_b[g][pos]);
              chk("beat_eof", out_eof, last_beat);
              if (last_beat) begin
                repeat (exp_len[g][0]) void'(exp_b[g].pop_front());
                void'(exp_len[g].pop_front());
                m_last        = g;
                last_xfer_cyc = x_cyc;
                gcnt          = 0;
                ph            = P_GAP;
              end else begin
                pos++;
              end
            end
          end
          if (exp_ab) begin
            abort_cnt++;
            abort_gi = grant_log.size();
            m_last   = g;
            pos      = 0;
            gcnt     = 0;
            ph       = P_GAP;
          end
        end

        default: begin
          chk("gap_val", out_val, 0);
          chk("gap_cts", req_cts, 0);
          chk("gap_abort", out_abort, 0);
          if (gcnt < IFG) begin
            chk("gap_busy", busy, 1);
            gcnt++;
          end else begin
            chk("gap_end_busy", busy, 0);
            prev_req  = req_val;
            have_prev = 1'b1;
            ph        = P_IDLE;
          end
        end
      endcase
    end
  end

  initial begin
    int ab0;
    int gl;
    for (int i = 0; i < N; i++) begin
      ptr[i]       = 0;
      hold[i]      = 0;
      stall_at[i]  = -1;
      stall_len[i] = 0;
    end

    // Reset state.
    repeat (4) @(negedge clk);
    chk("rst_req_cts", req_cts, 0);
    chk("rst_out_val", out_val, 0);
    chk("rst_out_dat", out_dat, 0);
    chk("rst_out_eof", out_eof, 0);
    chk("rst_out_abort", out_abort, 0);
    chk("rst_busy", busy, 0);
    chk("rst_gnt_idx", gnt_idx, N - 1);
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Round robin among 0,1,3 with two 4-byte frames each.
    for (int r = 0; r < 2; r++) begin
      send(0, 4);
      send(1, 4);
      send(3, 4);
    end
    drain("drain_rr", 2000);
    chk("rr_count", grant_log.size(), 6);
    if (grant_log.size() >= 6) begin
      chk("rr_order0", grant_log[0], 0);
      chk("rr_order1", grant_log[1], 1);
      chk("rr_order2", grant_log[2], 3);
      chk("rr_order3", grant_log[3], 0);
      chk("rr_order4", grant_log[4], 1);
      chk("rr_order5", grant_log[5], 3);
    end

    // Single 60-byte frame from source 2, MAC always ready.
    send(2, 60);
    drain("drain_len60", 2000);
    chk("len60_xfer_cycles", last_xfer_cyc, 60);

    // Source 1 stalls after 5 bytes long enough to trip the watchdog.
    ab0          = abort_cnt;
    stall_at[1]  = 5;
    stall_len[1] = 300;
    send(1, 12);
    begin
      int c;
      c = 0;
      while (c < 500 && hold[1] == 0) begin
        @(negedge clk);
        c++;
      end
      chk("stall_started", hold[1] > 0, 1);
    end
    send(2, 6);
    send(0, 6);
    drain("drain_stall", 4000);
    chk("stall_abort_count", abort_cnt - ab0, 1);
    if (grant_log.size() > abort_gi) chk("stall_next_grant", grant_log[abort_gi], 2);
    else chk("stall_next_grant", grant_log.size(), abort_gi + 1);

    // MAC ready toggling every cycle: backpressure must not abort.
    ab0      = abort_cnt;
    cts_mode = 1;
    send(1, 10);
    drain("drain_toggle", 2000);
    cts_mode = 0;
    chk_rng("toggle_xfer_cycles", last_xfer_cyc, 19, 20);
    chk("toggle_no_abort", abort_cnt - ab0, 0);

    // Last byte lands exactly when the stall count sits at TIMEOUT-1.
    ab0          = abort_cnt;
    stall_at[0]  = 3;
    stall_len[0] = TIMEOUT - 1;
    send(0, 4);
    drain("drain_eof_wd", 2000);
    chk("eof_wd_no_abort", abort_cnt - ab0, 0);
    chk("eof_wd_xfer_cycles", last_xfer_cyc, 4 + TIMEOUT - 1);

    // Reset mid-frame at byte 7, with source 2 waiting behind source 0.
    send(1, 6);
    drain("drain_pre_rst", 2000);
    send(0, 20);
    wait_ptr("wait_rst_start", 0, 1, 500);
    send(2, 8);
    wait_ptr("wait_rst_byte7", 0, 7, 500);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_val", out_val, 0);
    chk("midrst_req_cts", req_cts, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_abort", out_abort, 0);
    chk("midrst_gnt_idx", gnt_idx, N - 1);
    gl = grant_log.size();
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    drain("drain_post_rst", 3000);
    if (grant_log.size() > gl) chk("post_rst_first_grant", grant_log[gl], 0);
    else chk("post_rst_first_grant", grant_log.size(), gl + 1);

    // Random traffic with random MAC backpressure.
    cts_mode = 2;
    for (int b = 0; b < 3; b++) begin
      for (int f = 0; f < 8; f++) begin
        send($urandom_range(N - 1), $urandom_range(16, 1));
      end
      drain("drain_random", 6000);
    end
    cts_mode = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
